// File: rtl/alu_iss_queue_pkg.sv
// Shared widths, ALU command encoding and reservation-station payload types
// for the integer ALU issue queue.
package alu_iss_queue_pkg;

   localparam int unsigned DATA      = 32;
   localparam int unsigned ADDR      = 32;
   localparam int unsigned ROB_DEPTH = 16;
   localparam int unsigned ROB       = $clog2(ROB_DEPTH);
   localparam int unsigned DEPTH     = 4;
   localparam int unsigned IDX_W     = $clog2(DEPTH);
   localparam int unsigned CNT_W     = $clog2(DEPTH + 1);
   localparam int unsigned AREG_W    = 5;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLL  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9,
      ALU_BEQ  = 4'd10,
      ALU_BNE  = 4'd11
   } AluCommand_t;

   typedef struct packed {
      logic [AREG_W-1:0] areg;
      logic [ROB-1:0]    rob_id;
   } RegFile_t;

   typedef struct packed {
      logic            rdy;
      logic [ROB-1:0]  tag;
      logic [DATA-1:0] data;
   } AluIqSrc_t;

   typedef struct packed {
      logic            valid;
      RegFile_t        rd;
      AluCommand_t     command;
      AluIqSrc_t       src1;
      AluIqSrc_t       src2;
      logic [ADDR-1:0] pred_addr;
      logic            br_pred;
   } AluIqEntry_t;

   typedef struct packed {
      RegFile_t        rd;
      AluCommand_t     command;
      logic [DATA-1:0] data1;
      logic [DATA-1:0] data2;
      logic [ADDR-1:0] pred_addr;
      logic            br_pred;
   } AluIssue_t;

   // Capture a broadcast value into a pending source whose tag matches.
   function automatic AluIqSrc_t src_wake(input AluIqSrc_t s, input logic wb_e_,
                                          input logic [ROB-1:0] wb_tag,
                                          input logic [DATA-1:0] wb_data);
      AluIqSrc_t r;
      r = s;
      if (!s.rdy && !wb_e_ && (s.tag == wb_tag)) begin
         r.rdy  = 1'b1;
         r.data = wb_data;
      end
      return r;
   endfunction

endpackage

// File: rtl/alu_iss_queue_if.sv
// Dispatch, writeback-broadcast and issue signals of the ALU issue queue;
// slave is the queue side, master the surrounding pipeline.
interface alu_iss_queue_if;
   import alu_iss_queue_pkg::*;

   logic            flush_;
   logic            dis_e_;
   RegFile_t        dis_rd;
   AluCommand_t     dis_command;
   logic            dis_src1_rdy_;
   logic [ROB-1:0]  dis_src1_tag;
   logic [DATA-1:0] dis_src1_data;
   logic            dis_src2_rdy_;
   logic [ROB-1:0]  dis_src2_tag;
   logic [DATA-1:0] dis_src2_data;
   logic [ADDR-1:0] dis_pred_addr;
   logic            dis_br_pred;
   logic            iq_full;
   logic            wb_e_;
   logic [ROB-1:0]  wb_tag;
   logic [DATA-1:0] wb_data;
   logic            alu_busy;
   logic            issue_e_;
   RegFile_t        issue_rd;
   AluCommand_t     issue_command;
   logic [DATA-1:0] issue_data1;
   logic [DATA-1:0] issue_data2;
   logic [ADDR-1:0] issue_pred_addr;
   logic            issue_br_pred;

   modport slave (
      input  flush_, dis_e_, dis_rd, dis_command,
             dis_src1_rdy_, dis_src1_tag, dis_src1_data,
             dis_src2_rdy_, dis_src2_tag, dis_src2_data,
             dis_pred_addr, dis_br_pred,
             wb_e_, wb_tag, wb_data, alu_busy,
      output iq_full, issue_e_, issue_rd, issue_command,
             issue_data1, issue_data2, issue_pred_addr, issue_br_pred
   );

   modport master (
      output flush_, dis_e_, dis_rd, dis_command,
             dis_src1_rdy_, dis_src1_tag, dis_src1_data,
             dis_src2_rdy_, dis_src2_tag, dis_src2_data,
             dis_pred_addr, dis_br_pred,
             wb_e_, wb_tag, wb_data, alu_busy,
      input  iq_full, issue_e_, issue_rd, issue_command,
             issue_data1, issue_data2, issue_pred_addr, issue_br_pred
   );

endinterface

// File: rtl/alu_iss_select.sv
// Find-first-ready arbiter: lowest set request bit wins (oldest entry),
// reported as a one-hot grant plus its binary index.
module alu_iss_select #(
   parameter int unsigned N = 4
) (
   input  logic [N-1:0]         req,
   output logic [N-1:0]         grant,
   output logic [$clog2(N)-1:0] idx
);

   // Scan from the top so the lowest requester is the last one written.
   always_comb begin
      grant = '0;
      idx   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            grant    = '0;
            grant[i] = 1'b1;
            idx      = $clog2(N)'(i);
         end
      end
   end

endmodule

// File: rtl/alu_iss_queue.sv
// Integer ALU reservation station: in-order allocation into an age-ordered
// compacting array, wakeup from writeback, oldest-ready issue.
module alu_iss_queue
   import alu_iss_queue_pkg::*;
(
   input  logic             clk,
   input  logic             reset_,
   alu_iss_queue_if.slave   bus
);

   AluIqEntry_t      ent_q   [DEPTH];
   AluIqEntry_t      ent_wk  [DEPTH];
   AluIqEntry_t      ent_nxt [DEPTH];
   AluIqEntry_t      new_ent;
   logic [DEPTH-1:0] req;
   logic [DEPTH-1:0] grant;
   logic [IDX_W-1:0] sel_idx;
   logic [IDX_W-1:0] wr_idx;
   logic             issue_v;
   logic             dis_acc;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_nxt;
   logic             iq_full_q;
   logic             issue_e_q;
   AluIssue_t        issue_q;

   // Only entries ready at the start of the cycle compete; busy ALU masks all.
   always_comb begin
      req = '0;
      for (int i = 0; i < DEPTH; i++) begin
         req[i] = ent_q[i].valid & ent_q[i].src1.rdy & ent_q[i].src2.rdy & ~bus.alu_busy;
      end
   end

   alu_iss_select #(.N(DEPTH)) u_select (
      .req   (req),
      .grant (grant),
      .idx   (sel_idx)
   );

   assign issue_v = |grant;
   assign dis_acc = ~bus.dis_e_ & ~iq_full_q;
   assign wr_idx  = IDX_W'(count_q - CNT_W'(issue_v));

   // Incoming op, with same-cycle broadcast bypass on pending sources.
   always_comb begin
      new_ent           = '0;
      new_ent.valid     = 1'b1;
      new_ent.rd        = bus.dis_rd;
      new_ent.command   = bus.dis_command;
      new_ent.src1.rdy  = ~bus.dis_src1_rdy_;
      new_ent.src1.tag  = bus.dis_src1_tag;
      new_ent.src1.data = bus.dis_src1_data;
      new_ent.src2.rdy  = ~bus.dis_src2_rdy_;
      new_ent.src2.tag  = bus.dis_src2_tag;
      new_ent.src2.data = bus.dis_src2_data;
      new_ent.pred_addr = bus.dis_pred_addr;
      new_ent.br_pred   = bus.dis_br_pred;
      new_ent.src1      = src_wake(new_ent.src1, bus.wb_e_, bus.wb_tag, bus.wb_data);
      new_ent.src2      = src_wake(new_ent.src2, bus.wb_e_, bus.wb_tag, bus.wb_data);
   end

   // Wakeup first, then compact over the issued slot, then append dispatch.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         ent_wk[i] = ent_q[i];
         if (ent_q[i].valid) begin
            ent_wk[i].src1 = src_wake(ent_q[i].src1, bus.wb_e_, bus.wb_tag, bus.wb_data);
            ent_wk[i].src2 = src_wake(ent_q[i].src2, bus.wb_e_, bus.wb_tag, bus.wb_data);
         end
      end
      ent_nxt = ent_wk;
      for (int i = 0; i < DEPTH - 1; i++) begin
         if (issue_v && (IDX_W'(i) >= sel_idx)) begin
            ent_nxt[i] = ent_wk[i + 1];
         end
      end
      if (issue_v) begin
         ent_nxt[DEPTH-1] = '0;
      end
      if (dis_acc) begin
         ent_nxt[wr_idx] = new_ent;
      end
   end

   assign count_nxt = count_q + CNT_W'(dis_acc) - CNT_W'(issue_v);

   always_ff @(posedge clk) begin
      if (!reset_) begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_q[i] <= '0;
         end
         count_q   <= '0;
         iq_full_q <= 1'b0;
         issue_e_q <= 1'b1;
         issue_q   <= '0;
      end else if (!bus.flush_) begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_q[i] <= '0;
         end
         count_q   <= '0;
         iq_full_q <= 1'b0;
         issue_e_q <= 1'b1;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_q[i] <= ent_nxt[i];
         end
         count_q   <= count_nxt;
         iq_full_q <= (count_nxt == CNT_W'(DEPTH));
         issue_e_q <= ~issue_v;
         if (issue_v) begin
            issue_q.rd        <= ent_q[sel_idx].rd;
            issue_q.command   <= ent_q[sel_idx].command;
            issue_q.data1     <= ent_q[sel_idx].src1.data;
            issue_q.data2     <= ent_q[sel_idx].src2.data;
            issue_q.pred_addr <= ent_q[sel_idx].pred_addr;
            issue_q.br_pred   <= ent_q[sel_idx].br_pred;
         end
      end
   end

   assign bus.iq_full         = iq_full_q;
   assign bus.issue_e_        = issue_e_q;
   assign bus.issue_rd        = issue_q.rd;
   assign bus.issue_command   = issue_q.command;
   assign bus.issue_data1     = issue_q.data1;
   assign bus.issue_data2     = issue_q.data2;
   assign bus.issue_pred_addr = issue_q.pred_addr;
   assign bus.issue_br_pred   = issue_q.br_pred;

endmodule

// File: tb/tb_alu_iss_queue.sv
// Directed bench for alu_iss_queue: latency, wakeup, bypass, compaction,
// full/drop, flush and reset, each scenario checked inline.
module tb_alu_iss_queue;
   import alu_iss_queue_pkg::*;

   logic clk = 1'b0;
   logic reset_;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   alu_iss_queue_if bus ();

   alu_iss_queue dut (
      .clk    (clk),
      .reset_ (reset_),
      .bus    (bus)
   );

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      bus.flush_        = 1'b1;
      bus.dis_e_        = 1'b1;
      bus.dis_rd        = '0;
      bus.dis_command   = ALU_ADD;
      bus.dis_src1_rdy_ = 1'b1;
      bus.dis_src1_tag  = '0;
      bus.dis_src1_data = '0;
      bus.dis_src2_rdy_ = 1'b1;
      bus.dis_src2_tag  = '0;
      bus.dis_src2_data = '0;
      bus.dis_pred_addr = '0;
      bus.dis_br_pred   = 1'b0;
      bus.wb_e_         = 1'b1;
      bus.wb_tag        = '0;
      bus.wb_data       = '0;
      bus.alu_busy      = 1'b0;
   endtask

   // Drive one dispatch; pred_addr = 0x8000 + d1 and br_pred = d1[0].
   task automatic dispatch(input AluCommand_t cmd, input RegFile_t rd,
                           input logic r1_, input logic [ROB-1:0] t1, input logic [DATA-1:0] d1,
                           input logic r2_, input logic [ROB-1:0] t2, input logic [DATA-1:0] d2);
      bus.dis_e_        = 1'b0;
      bus.dis_rd        = rd;
      bus.dis_command   = cmd;
      bus.dis_src1_rdy_ = r1_;
      bus.dis_src1_tag  = t1;
      bus.dis_src1_data = d1;
      bus.dis_src2_rdy_ = r2_;
      bus.dis_src2_tag  = t2;
      bus.dis_src2_data = d2;
      bus.dis_pred_addr = ADDR'(32'h8000) + ADDR'(d1);
      bus.dis_br_pred   = d1[0];
   endtask

   task automatic test_reset;
      reset_ = 1'b0;
      idle_inputs();
      step();
      step();
      n_tests++; if (bus.issue_e_ !== 1'b1) begin n_fail++; $display("FAIL reset_issue_e: got %0b want 1", bus.issue_e_); end
      n_tests++; if (bus.iq_full !== 1'b0) begin n_fail++; $display("FAIL reset_iq_full: got %0b want 0", bus.iq_full); end
      n_tests++; if (bus.issue_data1 !== 32'h0) begin n_fail++; $display("FAIL reset_data1: got %0h want 0", bus.issue_data1); end
      n_tests++; if (bus.issue_data2 !== 32'h0) begin n_fail++; $display("FAIL reset_data2: got %0h want 0", bus.issue_data2); end
      reset_ = 1'b1;
      step();
   endtask

   task automatic test_latency;
      RegFile_t rd;
      rd.areg   = 5'd3;
      rd.rob_id = 4'd2;
      dispatch(ALU_ADD, rd, 1'b0, 4'd0, 32'd5, 1'b0, 4'd0, 32'd7);
      step();
      bus.dis_e_ = 1'b1;
      n_tests++; if (bus.issue_e_ !== 1'b1) begin n_fail++; $display("FAIL lat_cycle1_e: got %0b want 1", bus.issue_e_); end
      step();
      n_tests++; if (bus.issue_e_ !== 1'b0) begin n_fail++; $display("FAIL lat_cycle2_e: got %0b want 0", bus.issue_e_); end
      n_tests++; if (bus.issue_data1 !== 32'd5) begin n_fail++; $display("FAIL lat_data1: got %0h want 5", bus.issue_data1); end
      n_tests++; if (bus.issue_data2 !== 32'd7) begin n_fail++; $display("FAIL lat_data2: got %0h want 7", bus.issue_data2); end
      n_tests++; if (bus.issue_rd !== rd) begin n_fail++; $display("FAIL lat_rd: got %0h want %0h", bus.issue_rd, rd); end
      n_tests++; if (bus.issue_command !== ALU_ADD) begin n_fail++; $display("FAIL lat_cmd: got %0d want 0", bus.issue_command); end
      n_tests++; if (bus.issue_pred_addr !== 32'h8005) begin n_fail++; $display("FAIL lat_pred: got %0h want 8005", bus.issue_pred_addr); end
      n_tests++; if (bus.issue_br_pred !== 1'b1) begin n_fail++; $display("FAIL lat_br: got %0b want 1", bus.issue_br_pred); end
      n_tests++; if (bus.iq_full !== 1'b0) begin n_fail++; $display("FAIL lat_full: got %0b want 0", bus.iq_full); end
      step();
      n_tests++; if (bus.issue_e_ !== 1'b1) begin n_fail++; $display("FAIL lat_after_e: got %0b want 1", bus.issue_e_); end
   endtask

   task automatic test_wakeup;
      RegFile_t rd;
      rd = '0;
      dispatch(ALU_ADD, rd, 1'b1, 4'd3, 32'd0, 1'b0, 4'd0, 32'h11);
      step();
      dispatch(ALU_SUB, rd, 1'b0, 4'd0, 32'd10, 1'b0, 4'd0, 32'd20);
      step();
      bus.dis_e_ = 1'b1;
      step();
      n_tests++; if (bus.issue_e_ !== 1'b0) begin n_fail++; $display("FAIL wk_b_e: got %0b want 0", bus.issue_e_); end
      n_tests++; if (bus.issue_data1 !== 32'd10) begin n_fail++; $display("FAIL wk_b_data1: got %0h want a", bus.issue_data1); end
      n_tests++; if (bus.issue_command !== ALU_SUB) begin n_fail++; $display("FAIL wk_b_cmd: got %0d want 1", bus.issue_command); end
      bus.wb_e_   = 1'b0;
      bus.wb_tag  = 4'd3;
      bus.wb_data = 32'h1234;
      step();
      bus.wb_e_ = 1'b1;
      n_tests++; if (bus.issue_e_ !== 1'b1) begin n_fail++; $display("FAIL wk_woken_e: got %0b want 1", bus.issue_e_); end
      step();
      n_tests++; if (bus.issue_e_ !== 1'b0) begin n_fail++; $display("FAIL wk_a_e: got %0b want 0", bus.issue_e_); end
      n_tests++; if (bus.issue_data1 !== 32'h1234) begin n_fail++; $display("FAIL wk_a_data1: got %0h want 1234", bus.issue_data1); end
      n_tests++; if (bus.issue_data2 !== 32'h11) begin n_fail++; $display("FAIL wk_a_data2: got %0h want 11", bus.issue_data2); end
      step();
   endtask

   task automatic test_bypass;
      RegFile_t rd;
      rd = '0;
      bus.wb_e_   = 1'b0;
      bus.wb_tag  = 4'd9;
      bus.wb_data = 32'hAA;
      dispatch(ALU_OR, rd, 1'b0, 4'd0, 32'd3, 1'b1, 4'd9, 32'd0);
      step();
      idle_inputs();
      n_tests++; if (bus.issue_e_ !== 1'b1) begin n_fail++; $display("FAIL byp_cycle1_e: got %0b want 1", bus.issue_e_); end
      step();
      n_tests++; if (bus.issue_e_ !== 1'b0) begin n_fail++; $display("FAIL byp_e: got %0b want 0", bus.issue_e_); end
      n_tests++; if (bus.issue_data2 !== 32'hAA) begin n_fail++; $display("FAIL byp_data2: got %0h want aa", bus.issue_data2); end
      n_tests++; if (bus.issue_data1 !== 32'd3) begin n_fail++; $display("FAIL byp_data1: got %0h want 3", bus.issue_data1); end
      step();
   endtask

   // Middle entry issues while a younger one wakes in the same cycle.
   task automatic test_shift_wakeup;
      RegFile_t rd;
      rd = '0;
      bus.alu_busy = 1'b1;
      dispatch(ALU_ADD, rd, 1'b1, 4'd5, 32'd0, 1'b0, 4'd0, 32'h2);
      step();
      dispatch(ALU_ADD, rd, 1'b0, 4'd0, 32'h21, 1'b0, 4'd0, 32'h22);
      step();
      dispatch(ALU_ADD, rd, 1'b1, 4'd6, 32'd0, 1'b0, 4'd0, 32'h32);
      step();
      bus.dis_e_   = 1'b1;
      bus.alu_busy = 1'b0;
      bus.wb_e_    = 1'b0;
      bus.wb_tag   = 4'd6;
      bus.wb_data  = 32'h66;
      step();
      bus.wb_e_ = 1'b1;
      n_tests++; if (bus.issue_data1 !== 32'h21 || bus.issue_e_ !== 1'b0) begin n_fail++; $display("FAIL sh_b: got e=%0b d1=%0h want e=0 d1=21", bus.issue_e_, bus.issue_data1); end
      step();
      n_tests++; if (bus.issue_data1 !== 32'h66 || bus.issue_e_ !== 1'b0) begin n_fail++; $display("FAIL sh_c_d1: got e=%0b d1=%0h want e=0 d1=66", bus.issue_e_, bus.issue_data1); end
      n_tests++; if (bus.issue_data2 !== 32'h32) begin n_fail++; $display("FAIL sh_c_d2: got %0h want 32", bus.issue_data2); end
      bus.wb_e_   = 1'b0;
      bus.wb_tag  = 4'd5;
      bus.wb_data = 32'h55;
      step();
      bus.wb_e_ = 1'b1;
      n_tests++; if (bus.issue_e_ !== 1'b1) begin n_fail++; $display("FAIL sh_a_wait: got %0b want 1", bus.issue_e_); end
      step();
      n_tests++; if (bus.issue_data1 !== 32'h55 || bus.issue_e_ !== 1'b0) begin n_fail++; $display("FAIL sh_a: got e=%0b d1=%0h want e=0 d1=55", bus.issue_e_, bus.issue_data1); end
      step();
   endtask

   task automatic test_full;
      RegFile_t rd;
      rd = '0;
      bus.alu_busy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         dispatch(ALU_XOR, rd, 1'b0, 4'd0, DATA'(i + 1), 1'b0, 4'd0, DATA'(32'h100 + i));
         step();
      end
      n_tests++; if (bus.iq_full !== 1'b1) begin n_fail++; $display("FAIL full_set: got %0b want 1", bus.iq_full); end
      n_tests++; if (bus.issue_e_ !== 1'b1) begin n_fail++; $display("FAIL full_busy_e: got %0b want 1", bus.issue_e_); end
      dispatch(ALU_XOR, rd, 1'b0, 4'd0, 32'h99, 1'b0, 4'd0, 32'h99);
      step();
      bus.dis_e_ = 1'b1;
      n_tests++; if (bus.iq_full !== 1'b1) begin n_fail++; $display("FAIL full_drop: got %0b want 1", bus.iq_full); end
      bus.alu_busy = 1'b0;
      step();
      n_tests++; if (bus.issue_e_ !== 1'b0 || bus.issue_data1 !== 32'd1) begin n_fail++; $display("FAIL full_first: got e=%0b d1=%0h want e=0 d1=1", bus.issue_e_, bus.issue_data1); end
      n_tests++; if (bus.iq_full !== 1'b0) begin n_fail++; $display("FAIL full_clear: got %0b want 0", bus.iq_full); end
      for (int i = 1; i < 4; i++) begin
         step();
         n_tests++; if (bus.issue_e_ !== 1'b0 || bus.issue_data1 !== DATA'(i + 1)) begin n_fail++; $display("FAIL full_order%0d: got e=%0b d1=%0h want e=0 d1=%0h", i, bus.issue_e_, bus.issue_data1, i + 1); end
      end
      step();
      n_tests++; if (bus.issue_e_ !== 1'b1) begin n_fail++; $display("FAIL full_dropped_op: got e=%0b d1=%0h want e=1", bus.issue_e_, bus.issue_data1); end
   endtask

   task automatic test_flush;
      RegFile_t rd;
      rd = '0;
      bus.alu_busy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         dispatch(ALU_AND, rd, 1'b0, 4'd0, DATA'(32'h31 + i), 1'b0, 4'd0, 32'h0);
         step();
      end
      bus.dis_e_   = 1'b1;
      bus.alu_busy = 1'b0;
      step();
      n_tests++; if (bus.issue_e_ !== 1'b0 || bus.issue_data1 !== 32'h31) begin n_fail++; $display("FAIL fl_first: got e=%0b d1=%0h want e=0 d1=31", bus.issue_e_, bus.issue_data1); end
      bus.flush_ = 1'b0;
      dispatch(ALU_AND, rd, 1'b0, 4'd0, 32'h77, 1'b0, 4'd0, 32'h77);
      step();
      idle_inputs();
      n_tests++; if (bus.issue_e_ !== 1'b1) begin n_fail++; $display("FAIL fl_e: got %0b want 1", bus.issue_e_); end
      n_tests++; if (bus.iq_full !== 1'b0) begin n_fail++; $display("FAIL fl_full: got %0b want 0", bus.iq_full); end
      step();
      n_tests++; if (bus.issue_e_ !== 1'b1) begin n_fail++; $display("FAIL fl_empty_e: got %0b d1=%0h want 1", bus.issue_e_, bus.issue_data1); end
      n_tests++; if (bus.issue_data1 !== 32'h31) begin n_fail++; $display("FAIL fl_hold: got %0h want 31", bus.issue_data1); end
      dispatch(ALU_AND, rd, 1'b0, 4'd0, 32'h55, 1'b0, 4'd0, 32'h66);
      step();
      bus.dis_e_ = 1'b1;
      step();
      n_tests++; if (bus.issue_e_ !== 1'b0 || bus.issue_data1 !== 32'h55) begin n_fail++; $display("FAIL fl_redispatch: got e=%0b d1=%0h want e=0 d1=55", bus.issue_e_, bus.issue_data1); end
      n_tests++; if (bus.issue_data2 !== 32'h66) begin n_fail++; $display("FAIL fl_redispatch_d2: got %0h want 66", bus.issue_data2); end
      step();
   endtask

   task automatic test_reset_mid;
      RegFile_t rd;
      rd.areg   = 5'd7;
      rd.rob_id = 4'd4;
      dispatch(ALU_SLT, rd, 1'b0, 4'd0, 32'h41, 1'b0, 4'd0, 32'h42);
      step();
      bus.dis_e_ = 1'b1;
      reset_     = 1'b0;
      step();
      n_tests++; if (bus.issue_e_ !== 1'b1) begin n_fail++; $display("FAIL rm_e: got %0b want 1", bus.issue_e_); end
      n_tests++; if (bus.iq_full !== 1'b0) begin n_fail++; $display("FAIL rm_full: got %0b want 0", bus.iq_full); end
      n_tests++; if (bus.issue_data1 !== 32'h0 || bus.issue_data2 !== 32'h0) begin n_fail++; $display("FAIL rm_data: got %0h/%0h want 0/0", bus.issue_data1, bus.issue_data2); end
      n_tests++; if (bus.issue_rd !== RegFile_t'(0) || bus.issue_command !== ALU_ADD) begin n_fail++; $display("FAIL rm_ctrl: got rd=%0h cmd=%0d want 0/0", bus.issue_rd, bus.issue_command); end
      n_tests++; if (bus.issue_pred_addr !== 32'h0 || bus.issue_br_pred !== 1'b0) begin n_fail++; $display("FAIL rm_pred: got %0h/%0b want 0/0", bus.issue_pred_addr, bus.issue_br_pred); end
      reset_ = 1'b1;
      step();
      n_tests++; if (bus.issue_e_ !== 1'b1) begin n_fail++; $display("FAIL rm_no_issue: got %0b want 1", bus.issue_e_); end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_wakeup();
      test_bypass();
      test_shift_wakeup();
      test_full();
      test_flush();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
